// File: rtl/vga_gen_pkg.sv
// rtl/vga_gen_pkg.sv - shared constants and helpers for the scaled VGA image generator
package vga_gen_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int IMG_W_DEF   = 192;
   localparam int IMG_H_DEF   = 108;
   localparam int SCALE_DEF   = 10;
   localparam int COLOR_W_DEF = 8;
   localparam int CNT_W_DEF   = 12;

   localparam int RGB_W       = 3 * COLOR_W_DEF;
   localparam int FRAME_WORDS = IMG_W_DEF * IMG_H_DEF;
   localparam int ADDR_W      = clog2(FRAME_WORDS);
   localparam int RAM_ADDR_W  = ADDR_W + 1;

endpackage

// File: rtl/vga_scaled_image_generator_if.sv
// rtl/vga_scaled_image_generator_if.sv - host frame-write and buffer-swap port
interface vga_scaled_image_generator_if
   import vga_gen_pkg::*;
#(
   parameter int WA_W  = ADDR_W,
   parameter int PIX_W = RGB_W
) ();

   logic             wr_en;
   logic [WA_W-1:0]  wr_addr;
   logic [PIX_W-1:0] wr_data;
   logic             swap_req;
   logic             swap_done;

   modport master (output wr_en, wr_addr, wr_data, swap_req, input swap_done);
   modport slave  (input wr_en, wr_addr, wr_data, swap_req, output swap_done);

endinterface

// File: rtl/vga_frame_ram.sv
// rtl/vga_frame_ram.sv - simple dual-port RAM, synchronous read with one cycle latency
module vga_frame_ram
   import vga_gen_pkg::*;
#(
   parameter int DEPTH  = 2 * FRAME_WORDS,
   parameter int DATA_W = RGB_W,
   parameter int AW     = RAM_ADDR_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/vga_scaled_image_generator.sv
// rtl/vga_scaled_image_generator.sv - VGA timing with integer-scaled, double-buffered image overlay
module vga_scaled_image_generator
   import vga_gen_pkg::*;
#(
   parameter int IMG_W   = IMG_W_DEF,
   parameter int IMG_H   = IMG_H_DEF,
   parameter int SCALE   = SCALE_DEF,
   parameter int COLOR_W = COLOR_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [CNT_W-1:0]     h_total,
   input  logic [CNT_W-1:0]     h_sync,
   input  logic [CNT_W-1:0]     h_start,
   input  logic [CNT_W-1:0]     h_end,
   input  logic [CNT_W-1:0]     v_total,
   input  logic [CNT_W-1:0]     v_sync,
   input  logic [CNT_W-1:0]     v_start,
   input  logic [CNT_W-1:0]     v_end,
   input  logic [3*COLOR_W-1:0] bg_color,
   vga_scaled_image_generator_if.slave host,
   output logic                 frame_start,
   output logic                 front_sel,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_de,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b
);

   localparam int PIX_W   = 3 * COLOR_W;
   localparam int FRAME_N = IMG_W * IMG_H;
   localparam int WA_W    = clog2(FRAME_N);
   localparam int RA_W    = WA_W + 1;
   localparam int XI_W    = clog2(IMG_W + 1);
   localparam int YI_W    = clog2(IMG_H + 1);
   localparam int SUB_W   = (SCALE > 1) ? clog2(SCALE) : 1;

   logic [CNT_W-1:0] h_count, v_count;
   logic [SUB_W-1:0] x_sub, y_sub;
   logic [XI_W-1:0]  x_idx;
   logic [YI_W-1:0]  y_idx;
   logic [RA_W-1:0]  row_base;
   logic             swap_pend, swap_done_r;

   logic h_last, v_last, h_act, v_act, de0, hs0, vs0, in_img0, fs0, swap_now;
   logic x_wrap, y_wrap, wr_ok;
   logic [RA_W-1:0]  rd_addr, wr_ram_addr;
   logic [PIX_W-1:0] ram_q, pix;
   logic de1, hs1, vs1, in_img1, fs1;

   assign h_last   = (h_count == h_total);
   assign v_last   = (v_count == v_total);
   assign h_act    = (h_count >= h_start) && (h_count < h_end);
   assign v_act    = (v_count >= v_start) && (v_count < v_end);
   assign de0      = h_act && v_act;
   assign hs0      = (h_count >= h_sync) && !h_last;
   assign vs0      = (v_count >= v_sync) && !v_last;
   assign in_img0  = (x_idx < XI_W'(IMG_W)) && (y_idx < YI_W'(IMG_H));
   assign fs0      = (h_count == h_start) && (v_count == v_start);
   assign swap_now = h_last && v_last && swap_pend;
   assign x_wrap   = (x_sub == SUB_W'(SCALE - 1));
   assign y_wrap   = (y_sub == SUB_W'(SCALE - 1));

   // The two buffers sit back to back: buffer 1 starts at FRAME_N.
   assign rd_addr     = row_base + RA_W'(x_idx) + (front_sel ? RA_W'(FRAME_N) : '0);
   assign wr_ok       = host.wr_en && ({1'b0, host.wr_addr} < RA_W'(FRAME_N));
   assign wr_ram_addr = {1'b0, host.wr_addr} + (front_sel ? '0 : RA_W'(FRAME_N));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_count  <= '0;
         v_count  <= '0;
         x_sub    <= '0;
         x_idx    <= '0;
         y_sub    <= '0;
         y_idx    <= '0;
         row_base <= '0;
      end else begin
         if (h_last) begin
            h_count <= '0;
            v_count <= v_last ? '0 : v_count + 1'b1;
         end else begin
            h_count <= h_count + 1'b1;
         end

         if (h_last) begin
            x_sub <= '0;
            x_idx <= '0;
         end else if (h_act) begin
            x_sub <= x_wrap ? '0 : x_sub + 1'b1;
            if (x_wrap && (x_idx < XI_W'(IMG_W))) x_idx <= x_idx + 1'b1;
         end

         // Vertical scale state advances once per active line, at its last pixel clock.
         if (v_last) begin
            y_sub    <= '0;
            y_idx    <= '0;
            row_base <= '0;
         end else if (h_last && v_act) begin
            y_sub <= y_wrap ? '0 : y_sub + 1'b1;
            if (y_wrap && (y_idx < YI_W'(IMG_H))) begin
               y_idx    <= y_idx + 1'b1;
               row_base <= row_base + RA_W'(IMG_W);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         front_sel   <= 1'b0;
         swap_pend   <= 1'b0;
         swap_done_r <= 1'b0;
      end else begin
         front_sel   <= front_sel ^ swap_now;
         swap_done_r <= swap_now;
         swap_pend   <= swap_now ? host.swap_req : (swap_pend | host.swap_req);
      end
   end

   assign host.swap_done = swap_done_r;

   vga_frame_ram #(
      .DEPTH  (2 * FRAME_N),
      .DATA_W (PIX_W),
      .AW     (RA_W)
   ) u_frame_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_ram_addr),
      .wr_data (host.wr_data),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   assign pix = !de1 ? '0 : (in_img1 ? ram_q : bg_color);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de1         <= 1'b0;
         hs1         <= 1'b1;
         vs1         <= 1'b1;
         in_img1     <= 1'b0;
         fs1         <= 1'b0;
         vga_de      <= 1'b0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         frame_start <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else begin
         de1                   <= de0;
         hs1                   <= hs0;
         vs1                   <= vs0;
         in_img1               <= in_img0;
         fs1                   <= fs0;
         vga_de                <= de1;
         vga_hs                <= hs1;
         vga_vs                <= vs1;
         frame_start           <= fs1;
         {vga_r, vga_g, vga_b} <= pix;
      end
   end

endmodule

// File: tb/tb_vga_scaled_image_generator.sv
// tb/tb_vga_scaled_image_generator.sv - scoreboard bench for the scaled VGA image generator
module tb_vga_scaled_image_generator;

   typedef struct {
      int         h;
      int         v;
      bit         hs;
      bit         vs;
      bit         de;
      bit         fs;
      bit         known;
      logic [23:0] rgb;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] h_total = 12'd15, h_sync = 12'd1, h_start = 12'd3, h_end = 12'd13;
   logic [11:0] v_total = 12'd9, v_sync = 12'd1, v_start = 12'd2, v_end = 12'd8;
   logic [23:0] bg_color = 24'h00FF00;
   logic        frame_start, front_sel, vga_hs, vga_vs, vga_de;
   logic [7:0]  vga_r, vga_g, vga_b;

   vga_scaled_image_generator_if #(.WA_W(4), .PIX_W(24)) host ();

   vga_scaled_image_generator #(
      .IMG_W(4), .IMG_H(3), .SCALE(2), .COLOR_W(8), .CNT_W(12)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
      .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
      .bg_color(bg_color), .host(host),
      .frame_start(frame_start), .front_sel(front_sel),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #5 clk = ~clk;

   exp_t        q[$];
   int          done_t[$];
   int          total = 0, bad = 0, cyc = 0;
   int          mh = 0, mv = 0;
   bit          m_front = 0, m_pend = 0, track = 0, exp_front = 0, exp_done = 0;
   logic [23:0] mem [24];
   bit          known [24];

   function automatic exp_t rst_val();
      exp_t e;
      e.h = -1; e.v = -1; e.hs = 1; e.vs = 1; e.de = 0; e.fs = 0; e.known = 1; e.rgb = 24'h0;
      return e;
   endfunction

   // Expected output for timing position (h,v), straight from the timing table of the bench setup.
   function automatic exp_t calc(int h, int v);
      exp_t e;
      int x, y, a;
      e.h = h; e.v = v;
      e.hs = (h != 0) && (h != 15);
      e.vs = (v != 0) && (v != 9);
      e.de = (h >= 3) && (h < 13) && (v >= 2) && (v < 8);
      e.fs = (h == 3) && (v == 2);
      e.known = 1;
      e.rgb = 24'h0;
      if (e.de) begin
         x = (h - 3) / 2;
         y = (v - 2) / 2;
         if (x < 4 && y < 3) begin
            a = (m_front ? 12 : 0) + y * 4 + x;
            e.rgb = mem[a];
            e.known = known[a];
         end else begin
            e.rgb = bg_color;
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Producer: at each clock edge push the response for the counter state being consumed.
   initial begin
      int a;
      forever begin
         @(posedge clk);
         cyc++;
         if (track) begin
            q.push_back(calc(mh, mv));
            exp_done = (mh == 15) && (mv == 9) && m_pend;
            if (host.wr_en && host.wr_addr < 4'd12) begin
               a = (m_front ? 0 : 12) + int'(host.wr_addr);
               mem[a] = host.wr_data;
               known[a] = 1;
            end
            if (mh == 15 && mv == 9) begin
               if (m_pend) m_front = !m_front;
               m_pend = host.swap_req;
            end else begin
               m_pend = m_pend | host.swap_req;
            end
            exp_front = m_front;
            if (mh == 15) begin
               mh = 0;
               mv = (mv == 9) ? 0 : mv + 1;
            end else begin
               mh = mh + 1;
            end
         end
      end
   end

   // Monitor: compare presented outputs against the queue head.
   initial begin
      exp_t e;
      bit ok;
      forever begin
         @(negedge clk);
         if (track) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL pix_queue_empty got=0 want=1");
            end else begin
               e = q.pop_front();
               ok = (vga_hs == e.hs) && (vga_vs == e.vs) && (vga_de == e.de) && (frame_start == e.fs);
               if (e.known && ({vga_r, vga_g, vga_b} !== e.rgb)) ok = 0;
               if (!ok) begin
                  bad++;
                  $display("FAIL pix h=%0d v=%0d got hs=%b vs=%b de=%b fs=%b rgb=%h want hs=%b vs=%b de=%b fs=%b rgb=%h",
                           e.h, e.v, vga_hs, vga_vs, vga_de, frame_start, {vga_r, vga_g, vga_b},
                           e.hs, e.vs, e.de, e.fs, e.rgb);
               end
            end
            chk("front_sel", 32'(front_sel), 32'(exp_front));
            chk("swap_done", 32'(host.swap_done), 32'(exp_done));
            if (host.swap_done) done_t.push_back(cyc);
         end
      end
   end

   task automatic start_run();
      q.delete();
      q.push_back(rst_val());
      q.push_back(rst_val());
      mh = 0; mv = 0; m_front = 0; m_pend = 0; exp_front = 0; exp_done = 0;
      reset_n = 1'b1;
      track = 1;
   endtask

   task automatic wait_state(input int h, input int v);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #2;
         if (mh == h && mv == v) return;
      end
      total++; bad++;
      $display("FAIL wait_state timeout got=none want=(%0d,%0d)", h, v);
   endtask

   task automatic wr(input int addr, input logic [23:0] data);
      host.wr_en = 1'b1;
      host.wr_addr = 4'(addr);
      host.wr_data = data;
      @(posedge clk); #2;
      host.wr_en = 1'b0;
   endtask

   task automatic pulse_swap();
      host.swap_req = 1'b1;
      @(posedge clk); #2;
      host.swap_req = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
      chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
      chk({tag, "_de"}, 32'(vga_de), 32'd0);
      chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
      chk({tag, "_fs"}, 32'(frame_start), 32'd0);
      chk({tag, "_front"}, 32'(front_sel), 32'd0);
      chk({tag, "_done"}, 32'(host.swap_done), 32'd0);
   endtask

   initial begin
      int n;
      host.wr_en = 1'b0;
      host.wr_addr = '0;
      host.wr_data = '0;
      host.swap_req = 1'b0;
      for (int i = 0; i < 24; i++) begin
         mem[i] = 24'h0;
         known[i] = 0;
      end

      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs("rst");
      start_run();

      // Frame 0: fill buffer 1 with value = address, then swap it to the front.
      for (int a = 0; a < 12; a++) wr(a, 24'(a));
      pulse_swap();
      wait_state(0, 0);

      // Frame 1 (front 1): fill buffer 0; address 12 must be dropped.
      for (int a = 0; a < 12; a++) wr(a, 24'h000100 + 24'(a));
      wr(12, 24'hABCDEF);

      // Frame 2: back-buffer write during display, mid-frame swap request.
      wait_state(0, 0);
      done_t.delete();
      wait_state(5, 5);
      wr(0, 24'h5A5A5A);
      pulse_swap();
      wait_state(0, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("swap_once_cnt", 32'(done_t.size()), 32'd1);

      // Frame 3/4: request pending, second request on the swap cycle defers a further swap.
      done_t.delete();
      wait_state(4, 4);
      pulse_swap();
      wait_state(15, 9);
      pulse_swap();
      wait_state(0, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("defer_cnt", 32'(done_t.size()), 32'd2);
      if (done_t.size() == 2) chk("defer_gap", 32'(done_t[1] - done_t[0]), 32'd160);

      // Frame 5/6: swap to buffer 1, leave a request pending, then reset mid-frame.
      wait_state(2, 2);
      pulse_swap();
      wait_state(0, 0);
      wait_state(3, 3);
      pulse_swap();
      wait_state(7, 4);
      track = 0;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      #2;
      done_t.delete();
      start_run();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         n++;
         if (frame_start) break;
      end
      chk("fs_latency", 32'(n), 32'd37);
      wait_state(0, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("no_swap_after_rst", 32'(done_t.size()), 32'd0);

      track = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
